// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths and arbiter state encoding.
package wb_pkg;
    localparam int WB_AD_WIDTH  = 32;
    localparam int WB_DAT_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, OWN, ABORT} arb_state_e;
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational round-robin picker, first request at or after ptr.
module wb_rr_pick #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx
);
    logic [N-1:0] rot;
    logic [IW:0]  off;
    logic [IW:0]  sum;
    // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit wins.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = (IW + 1)'(i);
        sum  = {1'b0, ptr} + off;
        idx  = sum >= (IW + 1)'(N) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
        pick = |req ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin Wishbone arbiter with per-access watchdog abort.
module wb_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int WB_AD_WIDTH    = wb_pkg::WB_AD_WIDTH,
    parameter int WB_DAT_WIDTH   = wb_pkg::WB_DAT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS-1:0]                m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                m_stb_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*WB_AD_WIDTH-1:0]    m_addr_i,
    input  logic [NUM_MASTERS*WB_DAT_WIDTH-1:0]   m_wdata_i,
    input  logic [NUM_MASTERS*WB_DAT_WIDTH/8-1:0] m_sel_i,
    output logic [WB_DAT_WIDTH-1:0]               m_rdata_o,
    output logic [NUM_MASTERS-1:0]                m_ack_o,
    output logic [NUM_MASTERS-1:0]                m_err_o,
    output logic                                  s_cyc_o,
    output logic                                  s_stb_o,
    output logic                                  s_we_o,
    output logic [WB_AD_WIDTH-1:0]                s_addr_o,
    output logic [WB_DAT_WIDTH-1:0]               s_wdata_o,
    output logic [WB_DAT_WIDTH/8-1:0]             s_sel_o,
    input  logic [WB_DAT_WIDTH-1:0]               s_rdata_i,
    input  logic                                  s_ack_i,
    output logic [NUM_MASTERS-1:0]                grant_o
);
    import wb_pkg::*;

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = WB_DAT_WIDTH / 8;

    arb_state_e             state;
    logic [NUM_MASTERS-1:0] grant;
    logic [IW-1:0]          gidx;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          nxt_ptr;
    logic [15:0]            wd_cnt;
    logic [NUM_MASTERS-1:0] pick;
    logic [IW-1:0]          pick_idx;
    logic                   own;
    logic                   stb_g;

    wb_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req  (m_cyc_i),
        .ptr  (rr_ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    assign own     = state == OWN;
    assign stb_g   = m_stb_i[gidx];
    assign nxt_ptr = gidx == IW'(NUM_MASTERS - 1) ? '0 : gidx + 1'b1;

    always_comb begin
        s_cyc_o   = own && m_cyc_i[gidx];
        s_stb_o   = own && stb_g;
        s_we_o    = own && m_we_i[gidx];
        s_addr_o  = own ? m_addr_i[gidx*WB_AD_WIDTH +: WB_AD_WIDTH] : '0;
        s_wdata_o = own ? m_wdata_i[gidx*WB_DAT_WIDTH +: WB_DAT_WIDTH] : '0;
        s_sel_o   = own ? m_sel_i[gidx*SW +: SW] : '0;
        m_ack_o   = own ? grant & m_stb_i & {NUM_MASTERS{s_ack_i}} : '0;
        m_err_o   = state == ABORT ? grant : '0;
        m_rdata_o = s_rdata_i;
        grant_o   = grant;
    end

    // Releasing cyc takes priority over the watchdog so a timely drop never errors.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            grant  <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (|m_cyc_i) begin
                        grant <= pick;
                        gidx  <= pick_idx;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (!m_cyc_i[gidx]) begin
                        rr_ptr <= nxt_ptr;
                        grant  <= '0;
                        wd_cnt <= '0;
                        state  <= IDLE;
                    end else if (stb_g && !s_ack_i && wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        wd_cnt <= '0;
                        state  <= ABORT;
                    end else begin
                        wd_cnt <= (s_ack_i || !stb_g) ? '0 : wd_cnt + 1'b1;
                    end
                end
                ABORT: begin
                    rr_ptr <= nxt_ptr;
                    grant  <= '0;
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed checks of grant, pass-through, round-robin, timeout and reset.
module tb_wb_bus_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    cyc = '0, stb = '0, we = '0;
    logic [N*AW-1:0] addr = {32'h0000_0200, 32'h0000_0100};
    logic [N*DW-1:0] wdata = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    logic [N*SW-1:0] sel = {4'h3, 4'hF};
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ack, m_err, grant;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_sel;
    logic [DW-1:0]   s_rdata = '0;
    logic            s_ack = 1'b0;
    int              total = 0;
    int              bad = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.NUM_MASTERS(N), .WB_AD_WIDTH(AW), .WB_DAT_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m_cyc_i   (cyc),
        .m_stb_i   (stb),
        .m_we_i    (we),
        .m_addr_i  (addr),
        .m_wdata_i (wdata),
        .m_sel_i   (sel),
        .m_rdata_o (m_rdata),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_sel_o   (s_sel),
        .s_rdata_i (s_rdata),
        .s_ack_i   (s_ack),
        .grant_o   (grant)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [N-1:0] own;
        step; step; #1;
        chk("rst_grant", grant, 0);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_s_we", s_we, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_s_sel", s_sel, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_err", m_err, 0);
        step; rst = 1'b0;

        // single write by master 0, slave acks on the third owned cycle
        step; cyc = 2'b01; stb = 2'b01; we = 2'b01; #1;
        chk("w_idle_cyc", s_cyc, 0);
        chk("w_idle_grant", grant, 0);
        step; #1;
        chk("w_grant", grant, 2'b01);
        chk("w_s_cyc", s_cyc, 1);
        chk("w_s_stb", s_stb, 1);
        chk("w_s_we", s_we, 1);
        chk("w_s_addr", s_addr, 32'h100);
        chk("w_s_wdata", s_wdata, 32'hDEADBEEF);
        chk("w_s_sel", s_sel, 4'hF);
        chk("w_noack0", m_ack, 0);
        step; #1;
        chk("w_noack1", m_ack, 0);
        step; s_ack = 1'b1; #1;
        chk("w_ack", m_ack, 2'b01);
        step; s_ack = 1'b0; cyc = 0; stb = 0; we = 0; #1;
        chk("w_ack_done", m_ack, 0);
        chk("w_cyc_drop", s_cyc, 0);
        chk("w_grant_hold", grant, 2'b01);
        step; #1;
        chk("w_grant_clr", grant, 0);

        // both request each time; rr_ptr is 1 after master 0 released
        for (int i = 0; i < 4; i++) begin
            own = (i % 2 == 0) ? 2'b10 : 2'b01;
            step; cyc = 2'b11; stb = 2'b11; #1;
            chk("rr_idle_gap", grant, 0);
            chk("rr_idle_cyc", s_cyc, 0);
            step; s_ack = 1'b1; #1;
            chk("rr_owner", grant, own);
            chk("rr_ack", m_ack, own);
            chk("rr_s_addr", s_addr, own[1] ? 32'h200 : 32'h100);
            step; s_ack = 1'b0; cyc = ~own; stb = ~own; #1;
            chk("rr_release", s_cyc, 0);
        end
        step; cyc = 0; stb = 0; #1;
        chk("rr_end_grant", grant, 0);

        // master 1 burst of 4 while master 0 waits
        step; cyc = 2'b10; stb = 2'b10; #1;
        step; cyc = 2'b11; stb = 2'b11; s_ack = 1'b1; #1;
        chk("b_owner", grant, 2'b10);
        for (int i = 0; i < 4; i++) begin
            chk("b_ack", m_ack, 2'b10);
            chk("b_hold", grant, 2'b10);
            if (i < 3) step;
        end
        step; s_ack = 1'b0; cyc = 2'b01; stb = 2'b01; #1;
        chk("b_m1_drop", s_cyc, 0);
        step; #1;
        chk("b_gap", grant, 0);
        step; #1;
        chk("b_m0_grant", grant, 2'b01);
        chk("b_m0_addr", s_addr, 32'h100);
        step; cyc = 0; stb = 0; #1;

        // timeout: stb rises in IDLE, err 9 cycles later
        step; cyc = 2'b01; stb = 2'b01; #1;
        for (int k = 0; k < TO; k++) begin
            step; #1;
            chk("to_no_err", m_err, 0);
            chk("to_s_cyc", s_cyc, 1);
        end
        step; cyc = 0; stb = 0; #1;
        chk("to_err", m_err, 2'b01);
        chk("to_err_cyc", s_cyc, 0);
        chk("to_err_stb", s_stb, 0);
        chk("to_err_grant", grant, 2'b01);
        step; #1;
        chk("to_err_pulse", m_err, 0);
        chk("to_grant_clr", grant, 0);
        step; s_ack = 1'b1; #1;
        chk("to_late_ack", m_ack, 0);
        step; s_ack = 1'b0; #1;

        // reset while master 1 owns with stb high
        step; cyc = 2'b10; stb = 2'b10; #1;
        step; rst = 1'b1; #1;
        chk("r_own_cyc", s_cyc, 1);
        chk("r_own_grant", grant, 2'b10);
        step; s_ack = 1'b1; #1;
        chk("r_grant", grant, 0);
        chk("r_s_cyc", s_cyc, 0);
        chk("r_s_stb", s_stb, 0);
        chk("r_s_addr", s_addr, 0);
        chk("r_ack", m_ack, 0);
        chk("r_err", m_err, 0);
        step; rst = 1'b0; s_ack = 1'b0; cyc = 2'b11; stb = 2'b11; #1;
        step; #1;
        chk("r_regrant", grant, 2'b01);

        // read data pass-through in the ack cycle, non-owner stays quiet
        step; s_rdata = 32'h1234_5678; s_ack = 1'b1; #1;
        chk("rd_data", m_rdata, 32'h12345678);
        chk("rd_ack", m_ack, 2'b01);
        chk("rd_err", m_err, 0);
        step; s_ack = 1'b0; cyc = 0; stb = 0; #1;
        chk("rd_other_ack", m_ack, 0);
        step; #1;
        chk("rd_idle", grant, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
